// File: rtl/alu_pm_pkg.sv
// alu_pm_pkg: state and power-switch encodings shared by the idle monitor and the PMU
package alu_pm_pkg;
    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_COUNT  = 2'd1,
        ST_IDLE   = 2'd2,
        ST_WAKE   = 2'd3
    } pm_state_t;
    localparam int PSW_W = 4;
    localparam int ISO_W = 4;
    localparam logic [PSW_W-1:0] PSW_ALL_ON = 4'hF;
endpackage

// File: rtl/alu_idle_monitor_if.sv
// alu_idle_monitor_if: observed ALU inputs, PMU feedback and idle-monitor status
interface alu_idle_monitor_if #(parameter int WIDTH = 32);
    import alu_pm_pkg::*;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0] ALU_Sel;
    logic Cin;
    logic force_wake;
    logic [PSW_W-1:0] psw_ctrl;
    logic idle;
    logic wake_pulse;
    logic wake_err;
    logic [1:0] state;
    logic [15:0] quiet_cnt;
    modport master (
        output A, B, ALU_Sel, Cin, force_wake, psw_ctrl,
        input idle, wake_pulse, wake_err, state, quiet_cnt
    );
    modport slave (
        input A, B, ALU_Sel, Cin, force_wake, psw_ctrl,
        output idle, wake_pulse, wake_err, state, quiet_cnt
    );
endinterface

// File: rtl/alu_idle_monitor_activity_detect.sv
// activity_detect: flags any change of the observed bits versus last cycle, masked on the first post-reset cycle
module activity_detect #(parameter int N = 69) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] bits,
    output logic         activity
);
    logic [N-1:0] snap;
    logic primed;
    always_ff @(posedge clk) begin
        if (rst) begin
            snap   <= '0;
            primed <= 1'b0;
        end else begin
            snap   <= bits;
            primed <= 1'b1;
        end
    end
    assign activity = primed && (bits != snap);
endmodule

// File: rtl/alu_idle_monitor.sv
// alu_idle_monitor: raises idle after a run of quiet ALU cycles and supervises the PMU wake-up
module alu_idle_monitor
    import alu_pm_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDLE_THRESH = 8,
    parameter int WAKE_TIMEOUT = 16,
    parameter logic [PSW_W-1:0] PSW_ON = PSW_ALL_ON
) (
    input logic clk,
    input logic rst,
    alu_idle_monitor_if.slave bus
);
    localparam logic [15:0] THR = 16'(IDLE_THRESH);
    localparam logic [15:0] THR_LAST = 16'(IDLE_THRESH - 1);
    localparam logic [15:0] TMO_LAST = 16'(WAKE_TIMEOUT - 1);
    pm_state_t st, st_n;
    logic [15:0] cnt, cnt_n, tmr, tmr_n;
    logic idle_q, pulse_q, pulse_n, err_q, err_n;
    logic activity, quiet;
    activity_detect #(.N(2 * WIDTH + 5)) u_act (
        .clk(clk),
        .rst(rst),
        .bits({bus.A, bus.B, bus.ALU_Sel, bus.Cin}),
        .activity(activity)
    );
    assign quiet = !activity && !bus.force_wake;
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= ST_ACTIVE;
            cnt     <= '0;
            tmr     <= '0;
            idle_q  <= 1'b0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            st      <= st_n;
            cnt     <= cnt_n;
            tmr     <= tmr_n;
            idle_q  <= (st_n == ST_IDLE);
            pulse_q <= pulse_n;
            err_q   <= err_n;
        end
    end
    always_comb begin
        st_n    = st;
        cnt_n   = cnt;
        tmr_n   = tmr;
        pulse_n = 1'b0;
        err_n   = err_q;
        case (st)
            ST_ACTIVE: begin
                st_n  = quiet ? ST_COUNT : ST_ACTIVE;
                cnt_n = quiet ? 16'd1 : 16'd0;
            end
            ST_COUNT: begin
                st_n  = !quiet ? ST_ACTIVE : (cnt == THR_LAST) ? ST_IDLE : ST_COUNT;
                cnt_n = !quiet ? 16'd0 : (cnt == THR_LAST) ? THR : cnt + 16'd1;
            end
            ST_IDLE: begin
                cnt_n   = THR;
                st_n    = quiet ? ST_IDLE : ST_WAKE;
                pulse_n = !quiet;
                tmr_n   = '0;
            end
            ST_WAKE: begin
                // acknowledge is checked first so it beats a same-cycle timeout
                if (bus.psw_ctrl == PSW_ON) begin
                    st_n  = ST_ACTIVE;
                    cnt_n = '0;
                end else if (tmr == TMO_LAST) begin
                    st_n  = ST_ACTIVE;
                    cnt_n = '0;
                    err_n = 1'b1;
                end else begin
                    tmr_n = tmr + 16'd1;
                end
            end
        endcase
    end
    assign bus.idle       = idle_q;
    assign bus.wake_pulse = pulse_q;
    assign bus.wake_err   = err_q;
    assign bus.state      = st;
    assign bus.quiet_cnt  = cnt;
endmodule

// File: doc/alu_idle_monitor.md
Name: alu_idle_monitor

Overview:
Generates the `idle` request consumed by the PMU in the ALU+PMU top, closing the power-management loop from the datapath side. Watches the ALU operand/opcode inputs for activity and asserts `idle` after a programmable run of quiet cycles. On new activity or a forced wake, it drops `idle` and waits for the PMU to restore all power switches. Instantiated in top between the ALU input pins and PMU.idle.

Parameters:
WIDTH, 32, ALU operand width; must match the ALU.
IDLE_THRESH, 8, number of consecutive quiet cycles before `idle` asserts; legal range 2..65535.
WAKE_TIMEOUT, 16, maximum cycles spent in WAKE waiting for power-up before an error is flagged; must be >= 1.
PSW_ON, 4'hF, `psw_ctrl` value that means all domains are powered.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  synchronous, active-high reset.
A  input  WIDTH  ALU operand A (observed only).
B  input  WIDTH  ALU operand B (observed only).
ALU_Sel  input  4  ALU opcode (observed only).
Cin  input  1  ALU carry-in (observed only).
force_wake  input  1  level request to leave or prevent idle.
psw_ctrl  input  4  power-switch state from PMU, used as wake acknowledge.
idle  output  1  registered idle request to PMU.
wake_pulse  output  1  one-cycle pulse on the cycle idle deasserts.
wake_err  output  1  sticky flag: a wake exceeded WAKE_TIMEOUT.
state  output  2  current FSM state, for debug.
quiet_cnt  output  16  current count of consecutive quiet cycles.

Behaviour:
- Reset (rst=1 at a clk edge): state=ACTIVE(2'd0), idle=0, wake_pulse=0, wake_err=0, quiet_cnt=0, snapshot=0, primed=0.
- Snapshot: the {A,B,ALU_Sel,Cin} register is loaded every cycle.
  - activity = primed & ({A,B,ALU_Sel,Cin} != snapshot).
  - primed sets 1 the cycle after reset, so the first post-reset cycle is never counted as activity.
- quiet = ~activity & ~force_wake.
- States: ACTIVE=0, COUNT=1, IDLE=2, WAKE=3.
- ACTIVE:
  - quiet -> COUNT, quiet_cnt=1.
  - else stay in ACTIVE, quiet_cnt=0.
- COUNT:
  - ~quiet -> ACTIVE, quiet_cnt=0.
  - quiet and quiet_cnt==IDLE_THRESH-1 -> IDLE, idle<=1, quiet_cnt=IDLE_THRESH.
  - else quiet_cnt++.
  - Net effect: idle is visible high on the cycle after the IDLE_THRESH-th consecutive quiet cycle.
- IDLE:
  - idle=1; quiet_cnt saturates at IDLE_THRESH.
  - ~quiet -> WAKE, idle<=0, wake_pulse<=1 for exactly one cycle, wake timer=0.
- WAKE:
  - idle=0. Activity and force_wake are ignored; the snapshot still updates.
  - psw_ctrl==PSW_ON -> ACTIVE, quiet_cnt=0.
  - else if the wake timer reaches WAKE_TIMEOUT -> ACTIVE and wake_err<=1 (sticky until rst).
  - Both conditions in the same cycle: the acknowledge wins, no error.
- force_wake held high keeps the FSM out of COUNT/IDLE indefinitely.
- Activity and force_wake arriving in the same cycle count as a single wake event, giving one wake_pulse.
- rst mid-WAKE or mid-IDLE immediately returns all outputs to reset values; idle is never left asserted.
- quiet_cnt is zero-extended to 16 bits; counters never wrap.

Decomposition:
- Shared package alu_pm_pkg:
  - state encoding localparams (ST_ACTIVE, ST_COUNT, ST_IDLE, ST_WAKE);
  - PSW_ON / ISO constant widths, so PMU and this block share the encodings.
- One natural sub-module, activity_detect: snapshot register, primed flag, and the compare producing `activity`.
- FSM and counters stay in the top-level module.

Test Plan (IDLE_THRESH=8, WAKE_TIMEOUT=16):
1. Reset, then hold A=5, B=3, ALU_Sel=0, Cin=0 constant -> idle=0 for cycles 1..8 after reset release and idle=1 from cycle 9; quiet_cnt=8; state=2.
2. Quiet for 5 cycles, change B to 4 -> quiet_cnt returns to 0, state=ACTIVE, and a fresh 8-quiet-cycle count is needed before idle rises.
3. In IDLE, change A -> next cycle idle=0, wake_pulse=1 for one cycle, state=WAKE; drive psw_ctrl=4'hF 3 cycles later -> state=ACTIVE, wake_err=0.
4. In WAKE, hold psw_ctrl=4'h0 -> after 16 cycles state=ACTIVE and wake_err=1; wake_err stays 1 until rst, then reads 0.
5. force_wake=1 held while inputs are static -> idle never asserts. Release it -> idle asserts 8 quiet cycles later.
6. Pulse rst while in IDLE -> next cycle idle=0, state=0, quiet_cnt=0, wake_pulse=0, with no activity seen on the first primed cycle.
